// File: rtl/audio_mixer.sv
// audio_mixer
//   Time-multiplexed mixer for NUM_CH pulse-level audio channels, each with its
//   own volume. One sample is mixed per sample_stb. A sequential pass adds
//   +/-vol*GAIN for each channel into a non-overflowing accumulator. The sum is
//   then saturated to a signed OUT_W result.
//
//   Optional feature macro: AUDIO_MIXER_DCBLOCK_EN
//     When defined, the saturated mix goes through a first-order DC-blocking
//     filter in an extra FILT cycle. The filter is
//       y = x - x_prev + y_prev - (y_prev >>> 8)
//     When undefined, no filter state exists and the raw mix is output.
//
// Ports
//   clk        in   mixer clock (sysclk domain)
//   RES_n      in   asynchronous active-low reset
//   sample_stb in   one-cycle request to mix one sample
//   ch_level   in   per-channel pulse level (1 = positive half)
//   ch_vol     in   packed volumes; channel i at [i*VOL_W +: VOL_W]
//   ovr_clr    in   clears the sticky overrun flag
//   audio_out  out  signed mixed sample, held between updates
//   out_valid  out  one-cycle pulse when audio_out updates
//   busy       out  high while a mix pass is in progress
//   overrun    out  sticky: a strobe was dropped while busy
//   dbg_state  out  current FSM state encoding (IDLE=0, ACC=1, OUT=2, FILT=3)
//
// Handshake: sample_stb has no ready. It is accepted only in IDLE (busy=0).
// A strobe seen while busy=1 is dropped and sets overrun. out_valid is a pulse
// with no back-pressure.
module audio_mixer #(
  parameter int NUM_CH = 4,
  parameter int VOL_W  = 4,
  parameter int GAIN   = 1023,
  parameter int OUT_W  = 16
) (
  input  logic                    clk,
  input  logic                    RES_n,
  input  logic                    sample_stb,
  input  logic [NUM_CH-1:0]       ch_level,
  input  logic [NUM_CH*VOL_W-1:0] ch_vol,
  input  logic                    ovr_clr,
  output logic [OUT_W-1:0]        audio_out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun,
  output logic [1:0]              dbg_state
);

  localparam int GAIN_W  = $clog2(GAIN + 1);
  localparam int MAG_W   = VOL_W + GAIN_W;
  localparam int CON_W   = MAG_W + 1;
  localparam int CH_LOG  = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
  localparam int ACC_W   = CON_W + CH_LOG;
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int YW      = OUT_W + 2;
  // Wide enough to hold any intermediate without wrapping before clamping.
  localparam int WW      = ACC_W + OUT_W + 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2,
    FILT = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [NUM_CH-1:0]         snap_lvl_q, snap_lvl_d;
  logic [NUM_CH*VOL_W-1:0]   snap_vol_q, snap_vol_d;
  logic [OUT_W-1:0]          audio_out_q, audio_out_d;
  logic                      out_valid_q, out_valid_d;
  logic                      overrun_q, overrun_d;

  // Clamp v to the signed range of a 'bits'-wide value, result kept at WW bits.
  function automatic logic signed [WW-1:0] clamp(input logic signed [WW-1:0] v,
                                                 input int bits);
    logic signed [WW-1:0] maxv;
    logic signed [WW-1:0] minv;
    maxv = (WW'(1) <<< (bits - 1)) - WW'(1);
    minv = -maxv - WW'(1);
    if (v > maxv)      clamp = maxv;
    else if (v < minv) clamp = minv;
    else               clamp = v;
  endfunction

  // Contribution of the channel selected by idx.
  logic [VOL_W-1:0]          cur_vol;
  logic [MAG_W-1:0]          cur_mag;
  logic signed [CON_W-1:0]   cur_pos;
  logic signed [CON_W-1:0]   contrib;

  always_comb begin
    cur_vol = snap_vol_q[int'(idx_q) * VOL_W +: VOL_W];
    cur_mag = MAG_W'(cur_vol) * MAG_W'(GAIN);
    cur_pos = signed'({1'b0, cur_mag});
    contrib = snap_lvl_q[idx_q] ? cur_pos : -cur_pos;
  end

  logic signed [WW-1:0] mix_wide;
  logic [OUT_W-1:0]     mix_sat;

  always_comb begin
    mix_wide = clamp(WW'(acc_q), OUT_W);
    mix_sat  = OUT_W'(mix_wide);
  end

`ifdef AUDIO_MIXER_DCBLOCK_EN
  logic signed [OUT_W-1:0] mix_q, mix_d;
  logic signed [OUT_W-1:0] x_prev_q, x_prev_d;
  logic signed [YW-1:0]    y_prev_q, y_prev_d;
  logic signed [WW-1:0]    y_full;
  logic signed [WW-1:0]    y_int_w;
  logic signed [WW-1:0]    y_out_w;

  always_comb begin
    y_full  = WW'(mix_q) - WW'(x_prev_q) + WW'(y_prev_q) - WW'(y_prev_q >>> 8);
    y_int_w = clamp(y_full, YW);
    y_out_w = clamp(y_int_w, OUT_W);
  end
`endif

  // Next-state and datapath.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    snap_lvl_d  = snap_lvl_q;
    snap_vol_d  = snap_vol_q;
    audio_out_d = audio_out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
`ifdef AUDIO_MIXER_DCBLOCK_EN
    mix_d       = mix_q;
    x_prev_d    = x_prev_q;
    y_prev_d    = y_prev_q;
`endif

    // Clear first so that a simultaneous drop wins.
    if (ovr_clr) overrun_d = 1'b0;
    if (sample_stb && (state_q != IDLE)) overrun_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (sample_stb) begin
          snap_lvl_d = ch_level;
          snap_vol_d = ch_vol;
          acc_d      = '0;
          idx_d      = '0;
          state_d    = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + ACC_W'(contrib);
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_CH - 1)) state_d = OUT;
      end
      OUT: begin
`ifdef AUDIO_MIXER_DCBLOCK_EN
        mix_d   = signed'(mix_sat);
        state_d = FILT;
`else
        audio_out_d = mix_sat;
        out_valid_d = 1'b1;
        state_d     = IDLE;
`endif
      end
      FILT: begin
`ifdef AUDIO_MIXER_DCBLOCK_EN
        audio_out_d = OUT_W'(y_out_w);
        out_valid_d = 1'b1;
        x_prev_d    = mix_q;
        y_prev_d    = YW'(y_int_w);
`endif
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RES_n) begin
    if (!RES_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      snap_lvl_q  <= '0;
      snap_vol_q  <= '0;
      audio_out_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      snap_lvl_q  <= snap_lvl_d;
      snap_vol_q  <= snap_vol_d;
      audio_out_q <= audio_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef AUDIO_MIXER_DCBLOCK_EN
  always_ff @(posedge clk or negedge RES_n) begin
    if (!RES_n) begin
      mix_q    <= '0;
      x_prev_q <= '0;
      y_prev_q <= '0;
    end else begin
      mix_q    <= mix_d;
      x_prev_q <= x_prev_d;
      y_prev_q <= y_prev_d;
    end
  end
`endif

  assign audio_out = audio_out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_audio_mixer.sv
// tb_audio_mixer
//   Self-checking bench for audio_mixer at default parameters. Stimulus tasks
//   push the expected sample and its expected arrival cycle into queues. A
//   negedge monitor pops and compares them on every out_valid pulse.
module tb_audio_mixer;

  localparam int NUM_CH = 4;
  localparam int VOL_W  = 4;
  localparam int OUT_W  = 16;
`ifdef AUDIO_MIXER_DCBLOCK_EN
  localparam int LAT    = NUM_CH + 2;
`else
  localparam int LAT    = NUM_CH + 1;
`endif

  logic                    clk;
  logic                    RES_n;
  logic                    sample_stb;
  logic [NUM_CH-1:0]       ch_level;
  logic [NUM_CH*VOL_W-1:0] ch_vol;
  logic                    ovr_clr;
  logic [OUT_W-1:0]        audio_out;
  logic                    out_valid;
  logic                    busy;
  logic                    overrun;
  logic [1:0]              dbg_state;

  audio_mixer dut (
    .clk        (clk),
    .RES_n      (RES_n),
    .sample_stb (sample_stb),
    .ch_level   (ch_level),
    .ch_vol     (ch_vol),
    .ovr_clr    (ovr_clr),
    .audio_out  (audio_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  logic [OUT_W-1:0] exp_q[$];
  int               lat_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model
  int x_prev_m = 0;
  int y_prev_m = 0;

  function automatic int sat(input int v, input int bits);
    int hi;
    int lo;
    hi = (1 << (bits - 1)) - 1;
    lo = -(1 << (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] model(input logic [NUM_CH-1:0] lv,
                                             input logic [NUM_CH*VOL_W-1:0] vv);
    int s;
    int x;
    int y;
    s = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (lv[i]) s += int'(vv[i*VOL_W +: VOL_W]) * 1023;
      else       s -= int'(vv[i*VOL_W +: VOL_W]) * 1023;
    end
    x = sat(s, OUT_W);
`ifdef AUDIO_MIXER_DCBLOCK_EN
    y = sat(x - x_prev_m + y_prev_m - (y_prev_m >>> 8), OUT_W + 2);
    x_prev_m = x;
    y_prev_m = y;
    return OUT_W'(sat(y, OUT_W));
`else
    y = x;
    return OUT_W'(y);
`endif
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("audio_out", 32'(audio_out), 32'(exp_q.pop_front()));
        check("latency", 32'(cyc), 32'(lat_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic do_reset();
    RES_n = 1'b0;
    x_prev_m = 0;
    y_prev_m = 0;
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(posedge clk);
    #1 RES_n = 1'b1;
  endtask

  // Pulses sample_stb so it is sampled at the next edge (E0) and returns #1
  // after E0. Inputs are scrambled after the snapshot.
  task automatic send(input logic [NUM_CH-1:0] lv,
                      input logic [NUM_CH*VOL_W-1:0] vv, input bit push);
    @(posedge clk);
    #1;
    sample_stb = 1'b1;
    ch_level   = lv;
    ch_vol     = vv;
    @(posedge clk);
    #1;
    sample_stb = 1'b0;
    ch_level   = NUM_CH'($urandom);
    ch_vol     = (NUM_CH*VOL_W)'($urandom);
    if (push) begin
      exp_q.push_back(model(lv, vv));
      lat_q.push_back(cyc + LAT);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("idle_timeout", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic mix(input logic [NUM_CH-1:0] lv,
                     input logic [NUM_CH*VOL_W-1:0] vv);
    send(lv, vv, 1'b1);
    wait_idle();
  endtask

  logic [OUT_W-1:0] held;

  initial begin
    RES_n      = 1'b0;
    sample_stb = 1'b0;
    ch_level   = '0;
    ch_vol     = '0;
    ovr_clr    = 1'b0;
    #1;
    check("reset_audio_out", 32'(audio_out), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_overrun",   32'(overrun),   32'd0);
    do_reset();

    // Channel 0 only, positive; busy asserted right after acceptance.
    send(4'b0001, 16'h000F, 1'b1);
    check("busy_after_e0", 32'(busy), 32'd1);
    wait_idle();
    check("busy_after_out", 32'(busy), 32'd0);

    mix(4'b0000, 16'h000F);   // 0xC40F
    mix(4'b1111, 16'hFFFF);   // 0x7FFF
    mix(4'b0000, 16'hFFFF);   // 0x8000
    mix(4'b0001, 16'h00FF);   // cancellation -> 0

    for (int k = 0; k < 6; k++)
      mix(NUM_CH'($urandom_range(0, 15)), (NUM_CH*VOL_W)'($urandom_range(0, 65535)));

    // Overrun: a strobe two clocks after an accepted one is dropped.
    send(4'b0001, 16'h000F, 1'b1);
    @(posedge clk);
    #1 sample_stb = 1'b1;
    @(posedge clk);
    #1 sample_stb = 1'b0;
    check("overrun_set", 32'(overrun), 32'd1);
    wait_idle();
    held = audio_out;
    repeat (3) @(negedge clk);
    check("audio_out_held", 32'(audio_out), 32'(held));
    @(posedge clk);
    #1 ovr_clr = 1'b1;
    @(posedge clk);
    #1 ovr_clr = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'd0);

    // A drop coinciding with ovr_clr keeps overrun set.
    send(4'b0010, 16'h00A0, 1'b1);
    sample_stb = 1'b1;
    @(posedge clk);
    #1 ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    sample_stb = 1'b0;
    ovr_clr    = 1'b0;
    check("overrun_set_wins", 32'(overrun), 32'd1);
    wait_idle();
    @(posedge clk);
    #1 ovr_clr = 1'b1;
    @(posedge clk);
    #1 ovr_clr = 1'b0;
    check("overrun_cleared2", 32'(overrun), 32'd0);

    // Reset in the middle of a pass.
    send(4'b1111, 16'h1234, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 RES_n = 1'b0;
    x_prev_m = 0;
    y_prev_m = 0;
    @(negedge clk);
    check("midreset_busy",      32'(busy),      32'd0);
    check("midreset_audio_out", 32'(audio_out), 32'd0);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 RES_n = 1'b1;
    repeat (6) @(negedge clk);
    mix(4'b0001, 16'h000F);

`ifdef AUDIO_MIXER_DCBLOCK_EN
    for (int k = 0; k < 4; k++) mix(4'b0001, 16'h000F);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
